// File: rtl/input_conditioner.sv
// Player-control conditioning for the runner: 2-flop synchronisers, per-input
// debounce with live-selectable threshold, minimum-length jump shaping and jump-over-duck priority.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES      = 66000,
  parameter int unsigned SLOW_DEBOUNCE_CYCLES = 330000,
  parameter int unsigned JUMP_HOLD_CYCLES     = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_raw,
  input  logic        duck_raw,
  input  logic        slow,
  output logic        jumping,
  output logic        ducking,
  output logic        jump_pulse,
  output logic [15:0] jump_count
);

  localparam int unsigned MAX_T = (DEBOUNCE_CYCLES > SLOW_DEBOUNCE_CYCLES) ?
                                  DEBOUNCE_CYCLES : SLOW_DEBOUNCE_CYCLES;
  localparam int unsigned CW = $clog2(MAX_T + 1);
  localparam int unsigned HW = $clog2(JUMP_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;

  // Index 0 = jump, index 1 = duck
  logic [1:0]    sync1, sync2;
  logic [1:0]    stable;
  logic [CW-1:0] deb_cnt [2];
  logic [CW-1:0] thresh;

  logic          stable_jump_d;
  logic [HW-1:0] hold_cnt;
  logic [15:0]   count_q;
  state_t        state, next_state;
  logic          load_hold;

  assign thresh     = slow ? CW'(SLOW_DEBOUNCE_CYCLES) : CW'(DEBOUNCE_CYCLES);
  assign jump_count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {duck_raw, jump_raw};
      sync2 <= sync1;
    end
  end

  // Compare count+1 so a threshold lowered mid-count flips on the next differing cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int unsigned i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if ((deb_cnt[i] + CW'(1)) >= thresh) begin
          stable[i]  <= ~stable[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    load_hold  = 1'b0;
    case (state)
      IDLE: begin
        if (stable[0] && !stable_jump_d) begin
          next_state = HOLD;
          load_hold  = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) next_state = stable[0] ? RELEASE : IDLE;
      end
      RELEASE: begin
        if (!stable[0]) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs registered from next_state so ducking drops on the edge jumping rises
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      stable_jump_d <= 1'b0;
      hold_cnt      <= '0;
      count_q       <= '0;
      jumping       <= 1'b0;
      ducking       <= 1'b0;
      jump_pulse    <= 1'b0;
    end else begin
      state         <= next_state;
      stable_jump_d <= stable[0];
      jumping       <= (next_state != IDLE);
      ducking       <= stable[1] && (next_state == IDLE);
      jump_pulse    <= load_hold;
      if (load_hold) begin
        hold_cnt <= HW'(JUMP_HOLD_CYCLES - 1);
        if (count_q != '1) count_q <= count_q + 16'd1;
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with T=4 (fast), T=8 (slow), hold=10.
// Edge k is the first posedge sampling a newly driven raw level.
module tb_input_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_raw, duck_raw, slow;
  logic        jumping, ducking, jump_pulse;
  logic [15:0] jump_count;

  int errors = 0;
  int checks = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES      (4),
    .SLOW_DEBOUNCE_CYCLES (8),
    .JUMP_HOLD_CYCLES     (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .jump_raw   (jump_raw),
    .duck_raw   (duck_raw),
    .slow       (slow),
    .jumping    (jumping),
    .ducking    (ducking),
    .jump_pulse (jump_pulse),
    .jump_count (jump_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with jump already requested
    rst = 1'b1; jump_raw = 1'b1; duck_raw = 1'b0; slow = 1'b0;
    #2;
    chk1 ("rst_jumping", jumping, 1'b0);
    chk1 ("rst_ducking", ducking, 1'b0);
    chk1 ("rst_pulse", jump_pulse, 1'b0);
    chk16("rst_count", jump_count, 16'h0000);
    tick(1); rst = 1'b0;
    tick(6);                                   // after k+5
    chk1 ("rel_jump_k5", jumping, 1'b0);
    tick(1);                                   // after k+6
    chk1 ("rel_jump_k6", jumping, 1'b1);
    chk1 ("rel_pulse_k6", jump_pulse, 1'b1);
    chk16("rel_count", jump_count, 16'd1);
    tick(1);
    chk1 ("rel_pulse_k7", jump_pulse, 1'b0);
    jump_raw = 1'b0;
    tick(8);                                   // after k+15
    chk1 ("rel_hold_k15", jumping, 1'b1);
    tick(1);                                   // after k+16
    chk1 ("rel_end_k16", jumping, 1'b0);

    // Long press: raw high for edges k..k+19
    jump_raw = 1'b1;
    tick(6);
    chk1 ("long_k5", jumping, 1'b0);
    tick(1);
    chk1 ("long_k6", jumping, 1'b1);
    chk1 ("long_pulse_k6", jump_pulse, 1'b1);
    chk16("long_count", jump_count, 16'd2);
    tick(1);
    chk1 ("long_pulse_k7", jump_pulse, 1'b0);
    tick(12);                                  // after k+19
    jump_raw = 1'b0;
    tick(6);                                   // after k+25
    chk1 ("long_k25", jumping, 1'b1);
    tick(1);
    chk1 ("long_k26", jumping, 1'b0);
    chk16("long_count_end", jump_count, 16'd2);

    // 3-cycle glitch
    jump_raw = 1'b1;
    tick(3);
    jump_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk1("glitch_jump", jumping, 1'b0);
    end
    chk16("glitch_count", jump_count, 16'd2);

    // 5-cycle press: exactly 10 cycles of jumping
    jump_raw = 1'b1;
    tick(5);
    jump_raw = 1'b0;
    tick(1);
    chk1 ("short_k5", jumping, 1'b0);
    tick(1);
    chk1 ("short_k6", jumping, 1'b1);
    chk16("short_count", jump_count, 16'd3);
    tick(9);
    chk1 ("short_k15", jumping, 1'b1);
    tick(1);
    chk1 ("short_k16", jumping, 1'b0);
    tick(2);

    // Priority: duck held, jump accepted over it
    duck_raw = 1'b1;
    tick(6);
    chk1 ("duck_k5", ducking, 1'b0);
    tick(1);
    chk1 ("duck_k6", ducking, 1'b1);
    tick(2);
    jump_raw = 1'b1;
    tick(6);
    chk1 ("prio_duck_j5", ducking, 1'b1);
    chk1 ("prio_jump_j5", jumping, 1'b0);
    tick(1);
    chk1 ("prio_jump_j6", jumping, 1'b1);
    chk1 ("prio_duck_j6", ducking, 1'b0);
    jump_raw = 1'b0;
    tick(9);
    chk1 ("prio_jump_j15", jumping, 1'b1);
    chk1 ("prio_duck_j15", ducking, 1'b0);
    tick(1);
    chk1 ("prio_jump_j16", jumping, 1'b0);
    chk1 ("prio_duck_j16", ducking, 1'b1);
    duck_raw = 1'b0;
    tick(6);
    chk1 ("duckrel_d5", ducking, 1'b1);
    tick(1);
    chk1 ("duckrel_d6", ducking, 1'b0);
    chk16("prio_count", jump_count, 16'd4);

    // Slow mode: 6-cycle pulse ignored, 10-cycle accepted at k+10
    slow = 1'b1;
    jump_raw = 1'b1;
    tick(6);
    jump_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk1("slow_glitch", jumping, 1'b0);
    end
    jump_raw = 1'b1;
    tick(10);                                  // after k+9
    jump_raw = 1'b0;
    chk1 ("slow_k9", jumping, 1'b0);
    tick(1);
    chk1 ("slow_k10", jumping, 1'b1);
    chk16("slow_count", jump_count, 16'd5);
    tick(9);
    chk1 ("slow_k19", jumping, 1'b1);
    tick(1);
    chk1 ("slow_k20", jumping, 1'b0);
    slow = 1'b0;
    tick(2);

    // Second press whose stable edge lands in HOLD is dropped
    jump_raw = 1'b1;
    tick(5);
    jump_raw = 1'b0;
    tick(4);                                   // after k+8
    chk1 ("retrig_k8", jumping, 1'b1);
    chk16("retrig_count1", jump_count, 16'd6);
    jump_raw = 1'b1;
    tick(6);                                   // after k+14, stable rose in HOLD
    jump_raw = 1'b0;
    tick(1);
    chk1 ("retrig_pulse", jump_pulse, 1'b0);
    tick(1);                                   // after k+16: RELEASE
    chk1 ("retrig_k16", jumping, 1'b1);
    tick(4);
    chk1 ("retrig_k20", jumping, 1'b1);
    tick(1);
    chk1 ("retrig_k21", jumping, 1'b0);
    chk16("retrig_count2", jump_count, 16'd6);

    // Saturation, then asynchronous reset mid-HOLD
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    chk16("sat_forced", jump_count, 16'hFFFF);
    tick(1);
    jump_raw = 1'b1;
    tick(5);
    jump_raw = 1'b0;
    tick(2);                                   // after k+6
    chk1 ("sat_pulse", jump_pulse, 1'b1);
    chk16("sat_count", jump_count, 16'hFFFF);
    tick(2);                                   // mid-HOLD
    chk1 ("midhold_pre", jumping, 1'b1);
    rst = 1'b1;
    #1;
    chk1 ("midhold_jump", jumping, 1'b0);
    chk16("midhold_count", jump_count, 16'h0000);
    rst = 1'b0;
    tick(5);
    chk1 ("post_rst_jump", jumping, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
